// File: rtl/uart_master_pkg.sv
// Shared definitions for the UART bus master: command/response byte codes,
// FSM state encoding and the response serialiser count width.
package uart_master_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   // A response holds at most four bytes, so the count must reach 4.
   localparam int RESP_CNT_W = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ADDR  = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_WRITE = 3'd3;
   localparam state_t ST_READ  = 3'd4;
   localparam state_t ST_RESP  = 3'd5;

endpackage

// File: rtl/uart_resp_ser.sv
// Response serialiser: loads up to four bytes (LSB first) plus a count and
// hands them out one per tx_valid/tx_ready handshake, pulsing done on the last.
module uart_resp_ser
   import uart_master_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [31:0]           bytes_i,
   input  logic [RESP_CNT_W-1:0] count_i,
   input  logic                  tx_ready_i,
   output logic [7:0]            tx_byte_o,
   output logic                  tx_valid_o,
   output logic                  done_o
);

   logic [31:0]           buf_q, buf_d;
   logic [RESP_CNT_W-1:0] rem_q, rem_d;
   logic                  valid_q, valid_d;
   logic                  handshake;

   assign handshake = valid_q & tx_ready_i;

   // The outgoing byte always sits in the low lane; each handshake shifts the next one down.
   always_comb begin
      buf_d   = buf_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      if (load_i) begin
         buf_d   = bytes_i;
         rem_d   = count_i;
         valid_d = (count_i != '0);
      end else if (handshake) begin
         buf_d   = {8'h00, buf_q[31:8]};
         rem_d   = rem_q - 1'b1;
         valid_d = (rem_q != 3'd1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
      end
   end

   assign tx_byte_o  = buf_q[7:0];
   assign tx_valid_o = valid_q;
   assign done_o     = handshake & (rem_q == 3'd1);

endmodule

// File: rtl/uart_bus_master.sv
// UART command decoder acting as register-bus initiator ('W' addr d0..d3 / 'R' addr).
// Optional inter-byte timeout is compiled in with UART_MASTER_TIMEOUT_EN.
module uart_bus_master
   import uart_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
)
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  rx_byte_i,
   input  logic        rx_valid_i,
   output logic [7:0]  tx_byte_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        ren_o,
   output logic        we_o,
   output logic [7:0]  addr_o,
   output logic [31:0] wdata_o,
   input  logic [31:0] rdata_i,
   output logic        busy_o
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                state_q, state_d;
   logic [7:0]            addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  is_wr_q, is_wr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  send_nak;
   logic                  tmo_hit;
   logic                  ser_load;
   logic [31:0]           ser_bytes;
   logic [RESP_CNT_W-1:0] ser_count;
   logic                  ser_done;

   // Command parser; rx strobes outside IDLE/ADDR/DATA fall through and are dropped.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_wr_d   = is_wr_q;
      cnt_d     = cnt_q;
      send_nak  = 1'b0;
      ser_load  = 1'b0;
      ser_bytes = '0;
      ser_count = '0;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid_i) begin
               if (rx_byte_i == CMD_WRITE) begin
                  state_d = ST_ADDR;
                  is_wr_d = 1'b1;
               end else if (rx_byte_i == CMD_READ) begin
                  state_d = ST_ADDR;
                  is_wr_d = 1'b0;
               end else begin
                  send_nak = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (rx_valid_i) begin
               addr_d = rx_byte_i;
               if (is_wr_q) begin
                  state_d = ST_DATA;
                  cnt_d   = 2'd0;
               end else begin
                  state_d = ST_READ;
               end
            end else if (tmo_hit) begin
               send_nak = 1'b1;
            end
         end
         ST_DATA: begin
            if (rx_valid_i) begin
               wdata_d[{cnt_q, 3'b000} +: 8] = rx_byte_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_WRITE;
               end
            end else if (tmo_hit) begin
               send_nak = 1'b1;
            end
         end
         ST_WRITE: begin
            state_d   = ST_RESP;
            ser_load  = 1'b1;
            ser_bytes = {24'h0, RSP_ACK};
            ser_count = 3'd1;
         end
         ST_READ: begin
            state_d   = ST_RESP;
            ser_load  = 1'b1;
            ser_bytes = rdata_i;
            ser_count = 3'd4;
         end
         ST_RESP: begin
            if (ser_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (send_nak) begin
         state_d   = ST_RESP;
         ser_load  = 1'b1;
         ser_bytes = {24'h0, RSP_NAK};
         ser_count = 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef UART_MASTER_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] tmo_q, tmo_d;
   logic        in_wait;

   // Counts idle cycles between bytes of a command; any accepted byte restarts it.
   always_comb begin
      in_wait = (state_q == ST_ADDR) || (state_q == ST_DATA);
      tmo_d   = (rx_valid_i || !in_wait) ? 32'd0 : tmo_q + 32'd1;
   end

   assign tmo_hit = in_wait && !rx_valid_i && (tmo_q == TMO_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   uart_resp_ser u_resp_ser (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (ser_load),
      .bytes_i    (ser_bytes),
      .count_i    (ser_count),
      .tx_ready_i (tx_ready_i),
      .tx_byte_o  (tx_byte_o),
      .tx_valid_o (tx_valid_o),
      .done_o     (ser_done)
   );

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign we_o    = (state_q == ST_WRITE);
   assign ren_o   = (state_q == ST_READ);
   assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: a command-level model queues expected
// bus accesses and tx bytes; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_bus_master;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } bus_t;
   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_byte_o;
   logic        tx_valid_o;
   logic        ren_o;
   logic        we_o;
   logic [7:0]  addr_o;
   logic [31:0] wdata_o;
   logic [31:0] rdata_i;
   logic        busy_o;

   bus_t        exp_bus[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] resp_mem[256];
   logic [31:0] ref_mem[256];
   int          total = 0;
   int          bad = 0;
   int          ready_mode = 0;
   int          hold_cnt = 0;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_byte = 8'h00;
   bus_t        mon_e;
   logic [7:0]  mon_b;

   always #5 clk = ~clk;

   uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rx_byte_i  (rx_byte),
      .rx_valid_i (rx_valid),
      .tx_byte_o  (tx_byte_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready),
      .ren_o      (ren_o),
      .we_o       (we_o),
      .addr_o     (addr_o),
      .wdata_o    (wdata_o),
      .rdata_i    (rdata_i),
      .busy_o     (busy_o)
   );

   // Bus responder: a plain register file indexed by the bus address
   assign rdata_i = resp_mem[addr_o];
   always @(posedge clk) if (we_o) resp_mem[addr_o] <= wdata_o;

   // Transmitter ready: 0 = always ready, 1 = random, 2 = five stall cycles per byte
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = 1'($urandom_range(0, 1));
         default: begin
            if (!tx_valid_o) begin
               hold_cnt = 0;
               tx_ready = 1'b0;
            end else if (hold_cnt == 5) begin
               hold_cnt = 0;
               tx_ready = 1'b1;
            end else begin
               hold_cnt++;
               tx_ready = 1'b0;
            end
         end
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic noteFailure(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: event seen with nothing expected", name);
   endtask

   // Monitor: compares every strobe and every tx handshake against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (we_o || ren_o) begin
            checkOutput("strobe_excl", 32'(we_o & ren_o), 32'd0);
            if (exp_bus.size() == 0) begin
               noteFailure("unexpected_strobe");
            end else begin
               mon_e = exp_bus.pop_front();
               checkOutput("bus_kind", 32'(we_o), 32'(mon_e.wr));
               checkOutput("bus_addr", 32'(addr_o), 32'(mon_e.addr));
               if (mon_e.wr) checkOutput("bus_wdata", wdata_o, mon_e.data);
            end
         end
         if (hold_pend) begin
            checkOutput("tx_hold_valid", 32'(tx_valid_o), 32'd1);
            checkOutput("tx_hold_byte", 32'(tx_byte_o), 32'(hold_byte));
         end
         if (tx_valid_o && tx_ready) begin
            if (exp_tx.size() == 0) begin
               noteFailure("unexpected_tx");
            end else begin
               mon_b = exp_tx.pop_front();
               checkOutput("tx_byte", 32'(tx_byte_o), 32'(mon_b));
            end
         end
         hold_pend = tx_valid_o && !tx_ready;
         hold_byte = tx_byte_o;
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives bytes one per cycle, with optional random gaps; returns just after the last byte's edge
   task automatic applyStimulus(input bytes_t b, input int maxGap);
      foreach (b[i]) begin
         rx_byte  = b[i];
         rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0;
         if (maxGap > 0 && i != b.size() - 1) repeat ($urandom_range(0, maxGap)) tick();
      end
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      while (busy_o && n < limit) begin
         tick();
         n++;
      end
      checkOutput("idle_wait", 32'(busy_o), 32'd0);
   endtask

   // Command-level model: kind 0 = write, 1 = read, other = unknown command byte
   task automatic runCmd(input int kind, input logic [7:0] addr, input logic [31:0] data,
                         input logic [7:0] badByte, input int maxGap);
      bytes_t      b;
      bus_t        e;
      logic [31:0] w;
      if (kind == 0) begin
         b.push_back(8'h57);
         b.push_back(addr);
         for (int k = 0; k < 4; k++) b.push_back(data[8*k +: 8]);
         e.wr = 1'b1; e.addr = addr; e.data = data;
         exp_bus.push_back(e);
         ref_mem[addr] = data;
         exp_tx.push_back(8'h06);
      end else if (kind == 1) begin
         b.push_back(8'h52);
         b.push_back(addr);
         e.wr = 1'b0; e.addr = addr; e.data = 32'h0;
         exp_bus.push_back(e);
         w = ref_mem[addr];
         for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
      end else begin
         b.push_back(badByte);
         exp_tx.push_back(8'h15);
      end
      applyStimulus(b, maxGap);
   endtask

   initial begin
      bytes_t      b;
      bus_t        e;
      logic [31:0] w;
      logic [7:0]  bb;
      int          r;

      for (int i = 0; i < 256; i++) begin
         w = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
         if (i == 0) w = 32'h0007FFF9;
         resp_mem[i] <= w;
         ref_mem[i] = w;
      end

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("rst_tx_byte", 32'(tx_byte_o), 32'd0);
      checkOutput("rst_ren", 32'(ren_o), 32'd0);
      checkOutput("rst_we", 32'(we_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_addr", 32'(addr_o), 32'd0);
      checkOutput("rst_wdata", wdata_o, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] directed write");
      ready_mode = 0;
      runCmd(0, 8'h04, 32'h44332211, 8'h00, 0);
      checkOutput("wr_we_timing", 32'(we_o), 32'd1);
      checkOutput("wr_addr", 32'(addr_o), 32'h04);
      checkOutput("wr_wdata", wdata_o, 32'h44332211);
      tick();
      checkOutput("ack_valid", 32'(tx_valid_o), 32'd1);
      checkOutput("ack_byte", 32'(tx_byte_o), 32'h06);
      waitIdle(50);

      $display("[TB] directed read");
      runCmd(1, 8'h00, 32'h0, 8'h00, 0);
      checkOutput("rd_ren_timing", 32'(ren_o), 32'd1);
      checkOutput("rd_we_low", 32'(we_o), 32'd0);
      tick();
      checkOutput("rd_first_valid", 32'(tx_valid_o), 32'd1);
      checkOutput("rd_first_byte", 32'(tx_byte_o), 32'hF9);
      repeat (4) tick();
      checkOutput("rd_done_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("rd_done_busy", 32'(busy_o), 32'd0);

      $display("[TB] backpressure read and discarded rx during response");
      ready_mode = 2;
      runCmd(1, 8'h04, 32'h0, 8'h00, 0);
      waitIdle(200);
      runCmd(0, 8'h10, $urandom, 8'h00, 0);
      tick();
      rx_byte  = 8'h52;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      waitIdle(200);
      tick();
      checkOutput("rx_discard_busy", 32'(busy_o), 32'd0);

      $display("[TB] bad command");
      ready_mode = 0;
      runCmd(2, 8'h00, 32'h0, 8'h41, 0);
      waitIdle(50);
      tick();
      checkOutput("bad_busy", 32'(busy_o), 32'd0);

      $display("[TB] inter-byte timeout");
      b = '{8'h57, 8'h08, 8'hAA};
`ifdef UART_MASTER_TIMEOUT_EN
      exp_tx.push_back(8'h15);
      applyStimulus(b, 0);
      repeat (8) tick();
      checkOutput("tmo_still_busy", 32'(busy_o), 32'd1);
      waitIdle(60);
      checkOutput("tmo_addr", 32'(addr_o), 32'h08);
      checkOutput("tmo_wdata_lsb", 32'(wdata_o[7:0]), 32'hAA);
`else
      applyStimulus(b, 0);
      repeat (30) tick();
      checkOutput("notmo_busy", 32'(busy_o), 32'd1);
      checkOutput("notmo_tx_valid", 32'(tx_valid_o), 32'd0);
      e.wr = 1'b1; e.addr = 8'h08; e.data = 32'hDDCCBBAA;
      exp_bus.push_back(e);
      ref_mem[8'h08] = 32'hDDCCBBAA;
      exp_tx.push_back(8'h06);
      b = '{8'hBB, 8'hCC, 8'hDD};
      applyStimulus(b, 0);
      waitIdle(50);
`endif

      $display("[TB] reset during read response");
      e.wr = 1'b0; e.addr = 8'h08; e.data = 32'h0;
      exp_bus.push_back(e);
      w = ref_mem[8'h08];
      exp_tx.push_back(w[7:0]);
      exp_tx.push_back(w[15:8]);
      b = '{8'h52, 8'h08};
      applyStimulus(b, 0);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("midrst_busy", 32'(busy_o), 32'd0);
      checkOutput("midrst_ren", 32'(ren_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      runCmd(1, 8'h08, 32'h0, 8'h00, 0);
      waitIdle(50);

      $display("[TB] random commands");
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         do bb = 8'($urandom); while (bb == 8'h57 || bb == 8'h52);
         runCmd((r < 4) ? 0 : (r < 8) ? 1 : 2, 8'($urandom_range(0, 15)), $urandom, bb, 3);
         waitIdle(400);
      end

      repeat (3) tick();
      checkOutput("exp_tx_left", 32'(exp_tx.size()), 32'd0);
      checkOutput("exp_bus_left", 32'(exp_bus.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
